// File: rtl/wb_spi_xip_pkg.sv
// wb_spi_xip_pkg: shared state type, constants and byte-swap helper for the XIP bridge
package wb_spi_xip_pkg;
  typedef enum logic [2:0] {IDLE, CMD, CMD_WAIT, DATA, DATA_WAIT, RESP} xip_state_e;
  localparam logic [7:0] CMD_READ_DEF = 8'h03;
  localparam logic [3:0] PRESC_DEF = 4'd0;
  function automatic logic [31:0] bswap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction
endpackage

// File: rtl/wb_spi_xip_if.sv
// wb_spi_xip_if: host-side Wishbone read port of the XIP bridge
interface wb_spi_xip_if;
  logic cyc;
  logic stb;
  logic we;
  logic [23:0] adr;
  logic [31:0] dat;
  logic ack;
  modport master(output cyc, stb, we, adr, input dat, ack);
  modport slave(input cyc, stb, we, adr, output dat, ack);
endinterface

// File: rtl/wb_spi_xip.sv
// wb_spi_xip: Wishbone-to-SPI-flash execute-in-place bridge with a one-word hit buffer
module wb_spi_xip
  import wb_spi_xip_pkg::*;
#(
  parameter logic [3:0] PRESC = PRESC_DEF,
  parameter logic [7:0] CMD_READ = CMD_READ_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  wb_spi_xip_if.slave wbs,
  input  logic flush_i,
  output logic spim_cyc_o,
  output logic spim_stb_o,
  output logic spim_we_o,
  output logic [31:0] spim_dat_o,
  input  logic [31:0] spim_dat_i,
  input  logic spim_ack_i,
  output logic [3:0] spi_presc_o,
  output logic [1:0] spi_size_o,
  output logic spi_cpol_o,
  output logic spi_auto_cs_o,
  input  logic spi_rdy_i,
  output logic spi_cs_o
);
  xip_state_e state, nxt;
  logic [21:0] req_adr, buf_tag;
  logic [31:0] buf_data, dat_q;
  logic buf_valid, ack_q, cs_q, first;
  logic req, hit, done, fill, unused_adr;
  assign unused_adr = ^wbs.adr[1:0];
  assign req = wbs.cyc & wbs.stb & ~ack_q;
  assign hit = buf_valid & (wbs.adr[23:2] == buf_tag);
  assign done = ~first & spi_rdy_i;
  assign fill = (state == DATA_WAIT) & done;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = req ? ((wbs.we | hit) ? RESP : CMD) : IDLE;
      CMD:       nxt = spim_ack_i ? CMD_WAIT : CMD;
      CMD_WAIT:  nxt = done ? DATA : CMD_WAIT;
      DATA:      nxt = spim_ack_i ? DATA_WAIT : DATA;
      DATA_WAIT: nxt = done ? RESP : DATA_WAIT;
      default:   nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      req_adr <= '0;
      buf_tag <= '0;
      buf_data <= '0;
      dat_q <= '0;
      buf_valid <= 1'b0;
      ack_q <= 1'b0;
      cs_q <= 1'b1;
      first <= 1'b0;
    end else begin
      state <= nxt;
      first <= spim_stb_o;
      ack_q <= (state == RESP) & wbs.cyc & wbs.stb;
      buf_valid <= ~flush_i & (buf_valid | fill);
      if (state == IDLE && nxt == CMD) begin
        req_adr <= wbs.adr[23:2];
        cs_q <= 1'b0;
      end
      if (state == IDLE && nxt == RESP && !wbs.we) dat_q <= buf_data;
      if (fill) begin
        buf_data <= bswap32(spim_dat_i);
        dat_q <= bswap32(spim_dat_i);
        buf_tag <= req_adr;
        cs_q <= 1'b1;
      end
    end
  end
  assign spim_cyc_o = (state == CMD) | (state == DATA);
  assign spim_stb_o = spim_cyc_o;
  assign spim_we_o = spim_cyc_o;
  assign spim_dat_o = (state == CMD) ? {CMD_READ, req_adr, 2'b00} : 32'h0;
  assign wbs.dat = dat_q;
  assign wbs.ack = ack_q;
  assign spi_cs_o = cs_q;
  assign spi_presc_o = PRESC;
  assign spi_size_o = 2'd3;
  assign spi_cpol_o = 1'b0;
  assign spi_auto_cs_o = 1'b0;
endmodule
